// File: rtl/nibble_pack_pkg.sv
// Shared types and sizing helpers for the nibble-to-word packer.
package nibble_pack_pkg;

    // FILL accepts beats; HELD parks one completed word while the output is busy.
    typedef enum logic {FILL, HELD} pack_state_t;

    // Number of input beats per output word.
    function automatic int unsigned beats_f(input int unsigned in_w, input int unsigned out_w);
        return out_w / in_w;
    endfunction

    // Width able to hold a beat count of 0..beats (used for cnt and out_beats).
    function automatic int unsigned cntw_f(input int unsigned beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/pack_out_stage.sv
// Output register for the packer: holds one word under valid/ready and reports
// whether it can take a new word this cycle.
module pack_out_stage #(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNTW  = 3
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic [CNTW-1:0]  load_beats,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [CNTW-1:0]  out_beats,
    output logic             out_last,
    output logic             out_free
);

    // Register is free when empty or being drained this cycle.
    assign out_free = !out_valid || out_ready;

    // Load has priority so a pop and a load in one cycle give a back-to-back word.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_beats <= load_beats;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_word_packer.sv
// Packs IN_W-bit valid/ready beats into OUT_W-bit words, beat 0 in the LSBs.
// in_last closes a word early (zero-padded). A single hold register absorbs one
// completed word while the output register is stalled.
module nibble_word_packer
    import nibble_pack_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 16,
    localparam int unsigned BEATS = beats_f(IN_W, OUT_W),
    localparam int unsigned CNTW  = cntw_f(BEATS)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNTW-1:0]  out_beats,
    output logic             out_last
);

    if ((OUT_W % IN_W) != 0) begin : g_bad_ratio
        $error("nibble_word_packer: OUT_W must be a multiple of IN_W");
    end
    if (BEATS < 2) begin : g_bad_beats
        $error("nibble_word_packer: OUT_W/IN_W must be at least 2");
    end

    pack_state_t      state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0] hold_data_q, hold_data_d;
    logic [CNTW-1:0]  hold_beats_q, hold_beats_d;
    logic             hold_last_q, hold_last_d;

    logic [OUT_W-1:0] new_word;
    logic             accept;
    logic             complete;
    logic             out_free;
    logic             load;
    logic [OUT_W-1:0] load_data;
    logic [CNTW-1:0]  load_beats;
    logic             load_last;

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = arst_n && (state_q == FILL);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt_q == CNTW'(BEATS - 1)));

    // Accumulator with the incoming beat dropped into lane cnt; upper lanes stay zero.
    always_comb begin
        new_word = acc_q;
        for (int k = 0; k < int'(BEATS); k++) begin
            if (cnt_q == CNTW'(k)) new_word[k*IN_W +: IN_W] = in_data;
        end
    end

    // Next-state: beat accumulation, word completion and hold handling.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        hold_data_d  = hold_data_q;
        hold_beats_d = hold_beats_q;
        hold_last_d  = hold_last_q;
        load         = 1'b0;
        load_data    = new_word;
        load_beats   = cnt_q + CNTW'(1);
        load_last    = in_last;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        acc_d = '0;
                        cnt_d = '0;
                        if (out_free) begin
                            load = 1'b1;
                        end else begin
                            hold_data_d  = new_word;
                            hold_beats_d = cnt_q + CNTW'(1);
                            hold_last_d  = in_last;
                            state_d      = HELD;
                        end
                    end else begin
                        acc_d = new_word;
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            HELD: begin
                load_data  = hold_data_q;
                load_beats = hold_beats_q;
                load_last  = hold_last_q;
                if (out_free) begin
                    load    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Packer state registers; reset discards partial and held words.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= FILL;
            acc_q        <= '0;
            cnt_q        <= '0;
            hold_data_q  <= '0;
            hold_beats_q <= '0;
            hold_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            hold_beats_q <= hold_beats_d;
            hold_last_q  <= hold_last_d;
        end
    end

    pack_out_stage #(
        .OUT_W (OUT_W),
        .CNTW  (CNTW)
    ) u_out (
        .clk        (clk),
        .arst_n     (arst_n),
        .load       (load),
        .load_data  (load_data),
        .load_beats (load_beats),
        .load_last  (load_last),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_beats  (out_beats),
        .out_last   (out_last),
        .out_free   (out_free)
    );

endmodule

// File: tb/tb_nibble_word_packer.sv
// Self-checking bench for nibble_word_packer (IN_W=4, OUT_W=16).
module tb_nibble_word_packer;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_beats;
    logic        out_last;

    always #5 clk = ~clk;

    nibble_word_packer #(
        .IN_W  (4),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  beats;
        logic        last;
    } word_t;

    typedef struct {
        logic [3:0]  d;
        logic        l;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  eb;
        logic        el;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int accepts = 0;

    word_t      exp_q[$];
    logic [3:0] cur[$];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [2:0]  prev_beats;
    logic        prev_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: collect accepted beats, emit a word on last or when full.
    task automatic model_beat(input logic [3:0] d, input logic l);
        word_t w;
        cur.push_back(d);
        if (l || cur.size() == BEATS) begin
            w.data = '0;
            for (int k = 0; k < cur.size(); k++) w.data = w.data | (16'(cur[k]) << (4 * k));
            w.beats = 3'(cur.size());
            w.last  = l;
            exp_q.push_back(w);
            cur.delete();
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later.
    task automatic drive_cycle(input logic v, input logic [3:0] d, input logic l, input logic r);
        word_t w;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_beats", 32'(out_beats), 32'(prev_beats));
            chk("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (in_valid && in_ready) begin
            accepts++;
            model_beat(d, l);
        end
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(out_data), 32'hdead);
            end else begin
                w = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(w.data));
                chk("sb_beats", 32'(out_beats), 32'(w.beats));
                chk("sb_last", 32'(out_last), 32'(w.last));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_beats = out_beats;
        prev_last  = out_last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_beats", 32'(out_beats), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        exp_q.delete();
        cur.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    vec_t tbl[11];
    int   stalls;
    int   cycles;

    initial begin
        tbl[0]  = '{4'h1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[1]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[2]  = '{4'h3, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[3]  = '{4'h4, 1'b0, 1'b1, 16'h4321, 3'd4, 1'b0};
        tbl[4]  = '{4'hA, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[5]  = '{4'hB, 1'b1, 1'b1, 16'h00BA, 3'd2, 1'b1};
        tbl[6]  = '{4'hC, 1'b1, 1'b1, 16'h000C, 3'd1, 1'b1};
        tbl[7]  = '{4'h5, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[8]  = '{4'h6, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[9]  = '{4'h7, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        tbl[10] = '{4'h8, 1'b1, 1'b1, 16'h8765, 3'd4, 1'b1};

        // Reset state
        #3;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd0);
        do_reset();

        // Table: each beat followed by an idle check cycle
        foreach (tbl[i]) begin
            drive_cycle(1'b1, tbl[i].d, tbl[i].l, 1'b1);
            drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
                chk($sformatf("tbl%0d_beats", i), 32'(out_beats), 32'(tbl[i].eb));
                chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].el));
            end
        end

        // Backpressure: one word on the output, one in hold
        accepts = 0;
        for (int i = 1; i <= 8; i++) drive_cycle(1'b1, 4'(i), 1'b0, 1'b0);
        chk("bp_accepts", 32'(accepts), 32'd8);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_data", 32'(out_data), 32'h4321);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("bp_second_data", 32'(out_data), 32'h8765);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming throughput
        pops   = 0;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 4'(i), 1'b0, 1'b1);
            if (!in_ready) stalls++;
        end
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_words", 32'(pops), 32'd16);

        // Reset mid-word
        drive_cycle(1'b1, 4'hE, 1'b0, 1'b1);
        drive_cycle(1'b1, 4'hF, 1'b0, 1'b1);
        do_reset();
        pops = 0;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'(9 + i), 1'b0, 1'b1);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("rst_word_words", 32'(pops), 32'd1);

        // Reset while a word sits in hold
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 4'(i), 1'b0, 1'b0);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b0);
        chk("rst_held_ready", 32'(in_ready), 32'd0);
        do_reset();
        pops = 0;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'(3 + i), 1'b0, 1'b1);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("rst_held_words", 32'(pops), 32'd1);
        chk("rst_held_queue", 32'(exp_q.size()), 32'd0);

        // Random throttling
        accepts = 0;
        cycles  = 0;
        while (accepts < 1000 && cycles < 20000) begin
            drive_cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 5) == 0,
                        ($urandom % 3) != 0);
            cycles++;
        end
        chk("rand_budget", 32'(accepts >= 1000), 32'd1);
        // Close any partial word, then drain
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 4'h1, 1'b1, 1'b1);
            if (in_ready) i = 4;
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_partial_empty", 32'(cur.size()), 32'd0);
        chk("rand_out_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
